mem_rd_stream: RTL



---
 rtl/mem_rd_stream_pkg.sv | 23 ++
 rtl/sync_fifo_2.sv | 65 ++++++
 rtl/mem_rd_stream.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_rd_stream_pkg.sv
// ----------------------------------------------------------------------------
// Module   : mem_rd_stream_pkg
// Brief    : Shared state encodings and buffer depth for the read sequencer
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package mem_rd_stream_pkg;

   // Sequencer states; encodings are fixed so debug views stay stable
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Output buffer depth; also the read credit limit
   localparam int FIFO_DEPTH = 2;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_2.sv
// ----------------------------------------------------------------------------
// Module   : sync_fifo_2
// Brief    : Two-entry register FIFO, head entry always presented at head
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sync_fifo_2
   import mem_rd_stream_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [1:0]       cnt,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] entry0;
   logic [WIDTH-1:0] entry1;
   logic             pop_ok;
   logic             push_ok;

   // Pop only with data present; push into a full buffer only alongside a pop
   assign pop_ok  = pop & (cnt != 2'd0);
   assign push_ok = push & ((cnt < 2'(FIFO_DEPTH)) | pop_ok);
   assign head    = entry0;

   // Shift-style storage: entry0 is always the oldest word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry0 <= '0;
         entry1 <= '0;
         cnt    <= 2'd0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (cnt == 2'd0) entry0 <= wdata;
               else             entry1 <= wdata;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               entry0 <= entry1;
               cnt    <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  entry0 <= wdata;
               end else begin
                  entry0 <= entry1;
                  entry1 <= wdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_rd_stream.sv
// ----------------------------------------------------------------------------
// Module   : mem_rd_stream
// Brief    : Issues LEN consecutive reads from a 1-cycle-latency memory and
//            returns the words on a valid/ready stream via a 2-entry buffer
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mem_rd_stream
   import mem_rd_stream_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int MEM_DEPTH  = 256,
   parameter int WORD_BYTES = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   base_addr,
   input  logic [ADDR_WIDTH:0]     len,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic                    mem_ce,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [WORD_BYTES-1:0]   mem_be,
   input  logic [8*WORD_BYTES-1:0] mem_rd_data,
   output logic [8*WORD_BYTES-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam int                    DW        = 8 * WORD_BYTES;
   localparam logic [ADDR_WIDTH+1:0] DEPTH_LIM = (ADDR_WIDTH+2)'(MEM_DEPTH);

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] addr_hold;
   logic [ADDR_WIDTH:0]   rem_q;
   logic                  pending;
   logic [1:0]            fifo_cnt;
   logic                  pop;
   logic [2:0]            credit;
   logic                  issue;
   logic [ADDR_WIDTH+1:0] end_addr;

   // Range check is done two bits wider than the address so it cannot wrap
   assign end_addr = {2'b00, base_addr} + {1'b0, len};

   // Words held or in flight after this cycle decide whether a read may issue
   assign pop    = out_valid & out_ready;
   assign credit = {1'b0, fifo_cnt} + {2'b00, pending} - {2'b00, pop};
   assign issue  = (state == ST_READ) && (rem_q != '0) && (credit < 3'(FIFO_DEPTH));

   // The address bus shows the live address when reading, else the last one used
   assign mem_ce    = issue;
   assign mem_addr  = issue ? addr_q : addr_hold;
   assign mem_we    = 1'b0;
   assign mem_be    = '0;
   assign out_valid = (fifo_cnt != 2'd0);

   // Command sequencing, read issue bookkeeping and status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         addr_hold <= '0;
         rem_q     <= '0;
         pending   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done    <= 1'b0;
         err     <= 1'b0;
         pending <= issue;
         if (issue) begin
            addr_hold <= addr_q;
            addr_q    <= addr_q + ADDR_WIDTH'(1);
            rem_q     <= rem_q - (ADDR_WIDTH+1)'(1);
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (end_addr > DEPTH_LIM) begin
                     err <= 1'b1;
                  end else if (len == '0) begin
                     done <= 1'b1;
                  end else begin
                     addr_q <= base_addr;
                     rem_q  <= len;
                     busy   <= 1'b1;
                     state  <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (issue && (rem_q == (ADDR_WIDTH+1)'(1))) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!pending && (fifo_cnt == 2'd0)) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Read data is valid only the cycle after an issue, so push exactly then
   sync_fifo_2 #(
      .WIDTH (DW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (pending),
      .wdata (mem_rd_data),
      .pop   (pop),
      .cnt   (fifo_cnt),
      .head  (out_data)
   );

endmodule

`default_nettype wire
